// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit producing the HI/LO register pair.
// MULT/MULTU use radix-2 shift-add, DIV/DIVU use radix-2 restoring division;
// both take 32 CALC cycles plus one FIX cycle. MTHI/MTLO complete in IDLE.
module mul_div_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] opr_a_md_i,
   input  logic [31:0] opr_b_md_i,
   input  logic [2:0]  op_md_i,
   input  logic        start_md_i,
   output logic        busy_md_o,
   output logic        done_md_o,
   output logic [31:0] hi_md_o,
   output logic [31:0] lo_md_o
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q;
   logic        is_div_q, res_neg_q, dvd_neg_q, div_zero_q;
   logic [31:0] opr_b_q;
   // Multiply: {partial product, remaining multiplier bits}.
   // Divide:   {partial remainder, dividend bits shifting out / quotient bits shifting in}.
   logic [63:0] acc_q;

   logic        accept_md, is_signed, a_neg, b_neg;
   logic [31:0] mag_a, mag_b;
   logic [32:0] add_sum;
   logic [33:0] sub_diff;
   logic [63:0] acc_step;
   logic [63:0] prod_fix;
   logic [31:0] quot_fix, rem_fix;

   // Operand decode and magnitude extraction at start.
   always_comb begin
      accept_md = (state_q == IDLE) && start_md_i && !op_md_i[2];
      is_signed = !op_md_i[0];
      a_neg     = is_signed && opr_a_md_i[31];
      b_neg     = is_signed && opr_b_md_i[31];
      mag_a     = a_neg ? (~opr_a_md_i + 32'd1) : opr_a_md_i;
      mag_b     = b_neg ? (~opr_b_md_i + 32'd1) : opr_b_md_i;
   end

   // One radix-2 iteration of either multiply or divide.
   always_comb begin
      add_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opr_b_q} : 33'd0);
      sub_diff = {1'b0, acc_q[63:31]} - {2'b00, opr_b_q};
      acc_step = {add_sum, acc_q[31:1]};
      if (is_div_q) begin
         // Quotient bit is 1 when the trial difference is non-negative and fits in 32 bits.
         if (sub_diff[33:32] == 2'b00)
            acc_step = {sub_diff[31:0], acc_q[30:0], 1'b1};
         else
            acc_step = {acc_q[62:0], 1'b0};
      end
   end

   // Sign correction of the final magnitudes.
   // A zero divisor makes every trial subtract succeed, so the remainder ends
   // as the dividend magnitude and its sign restore yields the raw dividend.
   always_comb begin
      prod_fix = res_neg_q ? (~acc_q + 64'd1) : acc_q;
      quot_fix = res_neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
      if (div_zero_q)
         quot_fix = '1;
      rem_fix  = dvd_neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept_md) state_d = CALC;
         CALC:    if (cnt_q == 6'd31) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: operand latch at start, one iteration per CALC cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         is_div_q   <= 1'b0;
         res_neg_q  <= 1'b0;
         dvd_neg_q  <= 1'b0;
         div_zero_q <= 1'b0;
         opr_b_q    <= '0;
         acc_q      <= '0;
      end else if (accept_md) begin
         cnt_q      <= '0;
         is_div_q   <= op_md_i[1];
         res_neg_q  <= a_neg ^ b_neg;
         dvd_neg_q  <= a_neg;
         div_zero_q <= op_md_i[1] && (opr_b_md_i == 32'd0);
         opr_b_q    <= mag_b;
         acc_q      <= {32'd0, mag_a};
      end else if (state_q == CALC) begin
         cnt_q      <= cnt_q + 6'd1;
         acc_q      <= acc_step;
      end
   end

   // HI/LO, busy and done output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_md_o   <= '0;
         lo_md_o   <= '0;
         busy_md_o <= 1'b0;
         done_md_o <= 1'b0;
      end else begin
         busy_md_o <= (state_d != IDLE);
         done_md_o <= (state_q == FIX);
         if (state_q == FIX) begin
            if (is_div_q) begin
               hi_md_o <= rem_fix;
               lo_md_o <= quot_fix;
            end else begin
               hi_md_o <= prod_fix[63:32];
               lo_md_o <= prod_fix[31:0];
            end
         end else if (state_q == IDLE && start_md_i) begin
            if (op_md_i == 3'b100) hi_md_o <= opr_a_md_i;
            if (op_md_i == 3'b101) lo_md_o <= opr_a_md_i;
         end
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed + reference-model scoreboard bench for mul_div_unit.
module tb_mul_div_unit;

   logic        clk;
   logic        rst_n;
   logic [31:0] opr_a_md_i, opr_b_md_i;
   logic [2:0]  op_md_i;
   logic        start_md_i;
   logic        busy_md_o, done_md_o;
   logic [31:0] hi_md_o, lo_md_o;

   typedef struct {
      string       tag;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   mul_div_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opr_a_md_i (opr_a_md_i),
      .opr_b_md_i (opr_b_md_i),
      .op_md_i    (op_md_i),
      .start_md_i (start_md_i),
      .busy_md_o  (busy_md_o),
      .done_md_o  (done_md_o),
      .hi_md_o    (hi_md_o),
      .lo_md_o    (lo_md_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference results {HI, LO} from plain SV arithmetic.
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] r;
      int          sa, sb2;
      sa  = a;
      sb2 = b;
      r   = '0;
      case (op)
         3'd0: r = {{32{a[31]}}, a} * {{32{b[31]}}, b};
         3'd1: r = {32'd0, a} * {32'd0, b};
         3'd2: begin
            if (b == 32'd0)                                r = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == '1)        r = {32'd0, 32'h8000_0000};
            else                                           r = {32'(sa % sb2), 32'(sa / sb2)};
         end
         3'd3: begin
            if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
            else            r = {a % b, a / b};
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a mul/div, optionally inject an MTLO at cycle inj, then scoreboard-check.
   task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input string tag,
                         input bit tail, input int inj);
      exp_t        e;
      int          lat, busy_cnt;
      bit          hold_bad;
      logic [31:0] hi0, lo0;
      sb.push_back('{tag, ehi, elo});
      op_md_i    = op;
      opr_a_md_i = a;
      opr_b_md_i = b;
      start_md_i = 1'b1;
      tick();
      start_md_i = 1'b0;
      opr_a_md_i = $urandom;
      opr_b_md_i = $urandom;
      hi0 = hi_md_o;
      lo0 = lo_md_o;
      lat = 0;
      busy_cnt = 0;
      hold_bad = 0;
      while (!done_md_o && lat < 60) begin
         if (busy_md_o) busy_cnt++;
         if (hi_md_o !== hi0 || lo_md_o !== lo0) hold_bad = 1;
         if (inj != 0 && lat == inj) begin
            op_md_i    = 3'b101;
            opr_a_md_i = 32'h0000_AAAA;
            start_md_i = 1'b1;
         end else if (inj != 0 && lat == inj + 1) begin
            op_md_i    = 3'b100;
            start_md_i = 1'b1;
         end else begin
            start_md_i = 1'b0;
         end
         tick();
         lat++;
      end
      start_md_i = 1'b0;
      chk({tag, "_latency"}, 32'(lat), 32'd33);
      chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
      chk({tag, "_busy_low_at_done"}, {31'd0, busy_md_o}, 32'd0);
      chk({tag, "_hold_during_calc"}, {31'd0, hold_bad}, 32'd0);
      e = sb.pop_front();
      chk({e.tag, "_hi"}, hi_md_o, e.hi);
      chk({e.tag, "_lo"}, lo_md_o, e.lo);
      if (tail) begin
         tick();
         chk({tag, "_done_one_cycle"}, {31'd0, done_md_o}, 32'd0);
      end
   endtask

   task automatic run_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [63:0] r;
      r = model(op, a, b);
      run_md(op, a, b, r[63:32], r[31:0], tag, 1'b1, 0);
   endtask

   // Single-cycle op (MTHI/MTLO/no-op) issued from IDLE.
   task automatic run_mt(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] ehi, input logic [31:0] elo, input string tag);
      op_md_i    = op;
      opr_a_md_i = a;
      start_md_i = 1'b1;
      tick();
      start_md_i = 1'b0;
      chk({tag, "_hi"}, hi_md_o, ehi);
      chk({tag, "_lo"}, lo_md_o, elo);
      chk({tag, "_busy"}, {31'd0, busy_md_o}, 32'd0);
      chk({tag, "_done"}, {31'd0, done_md_o}, 32'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      start_md_i = 1'b0;
      op_md_i    = '0;
      opr_a_md_i = '0;
      opr_b_md_i = '0;
      repeat (3) tick();
      chk("reset_hi", hi_md_o, 32'd0);
      chk("reset_lo", lo_md_o, 32'd0);
      chk("reset_busy", {31'd0, busy_md_o}, 32'd0);
      chk("reset_done", {31'd0, done_md_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      run_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 1'b1, 0);
      run_md(3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg", 1'b1, 0);
      run_md(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg", 1'b1, 0);
      run_md(3'd3, 32'd7, 32'd2, 32'd1, 32'd3, "divu_7_2", 1'b0, 0);
      // started in the done cycle of the previous op
      run_md(3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, "divu_by_zero", 1'b1, 0);
      run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf", 1'b1, 0);
      run_md(3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_neg_by_zero", 1'b1, 0);

      run_mt(3'b100, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF, "mthi");
      run_md(3'd1, 32'h0001_0000, 32'h0003_0001, 32'h0000_0003, 32'h0001_0000, "multu_mt_ignored", 1'b1, 10);
      run_mt(3'b101, 32'h0000_BEEF, 32'h0000_0003, 32'h0000_BEEF, "mtlo");
      run_mt(3'b110, 32'hDEAD_DEAD, 32'h0000_0003, 32'h0000_BEEF, "nop6");
      run_mt(3'b111, 32'hDEAD_DEAD, 32'h0000_0003, 32'h0000_BEEF, "nop7");

      for (int i = 0; i < 6; i++) begin
         logic [2:0]  op;
         logic [31:0] a, b;
         op = 3'($urandom_range(0, 3));
         a  = $urandom;
         b  = (i == 5) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
         if (i == 4) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         run_model(op, a, b, $sformatf("rand%0d_op%0d", i, op));
      end

      // Reset in the middle of a divide.
      run_mt(3'b100, 32'h0000_DEAD, 32'h0000_DEAD, lo_md_o, "pre_reset_mthi");
      op_md_i    = 3'd3;
      opr_a_md_i = 32'd100;
      opr_b_md_i = 32'd7;
      start_md_i = 1'b1;
      tick();
      start_md_i = 1'b0;
      repeat (14) tick();
      chk("pre_reset_busy", {31'd0, busy_md_o}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_hi", hi_md_o, 32'd0);
      chk("async_reset_lo", lo_md_o, 32'd0);
      chk("async_reset_busy", {31'd0, busy_md_o}, 32'd0);
      chk("async_reset_done", {31'd0, done_md_o}, 32'd0);
      repeat (2) tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post_reset_idle_busy", {31'd0, busy_md_o}, 32'd0);
      run_md(3'd0, 32'd2, 32'd3, 32'd0, 32'd6, "mult_after_reset", 1'b1, 0);

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
